// File: rtl/sha1_block_sequencer_if.sv
// Bus bundle for the SHA-1 block sequencer: Wishbone slave side plus the
// message-word stream and completion handshake toward the compression core.
interface sha1_block_sequencer_if;
  logic         wbs_stb_i;
  logic         wbs_cyc_i;
  logic         wbs_we_i;
  logic [3:0]   wbs_sel_i;
  logic [31:0]  wbs_adr_i;
  logic [31:0]  wbs_dat_i;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic         core_w_valid;
  logic [31:0]  core_w_data;
  logic         core_w_ready;
  logic         core_init;
  logic         core_done;
  logic [159:0] core_digest;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  core_w_valid, core_w_data, core_init,
    output core_w_ready, core_done, core_digest
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output core_w_valid, core_w_data, core_init,
    input  core_w_ready, core_done, core_digest
  );
endinterface

// File: rtl/sha1_block_sequencer.sv
// Buffers one 512-bit message block written over Wishbone, streams it into the
// SHA-1 core as 16 words, waits for core_done and raises DONE / irq.
module sha1_block_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   active,
  output logic                   irq,
  sha1_block_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  logic [31:0] r_buf [16];
  logic [4:0]  r_count;
  logic [3:0]  r_rd;
  logic        r_ack;
  logic [31:0] r_dat;
  logic        r_valid;
  logic [31:0] r_wdata;
  logic        r_core_init;
  logic        r_init_en;
  logic        r_irq_en;
  logic        r_done;
  logic        r_err;

  logic        w_hit, w_acc, w_wr;
  logic        w_wr_ctrl, w_wr_stat, w_wr_msg;
  logic        w_idle, w_busy, w_full;
  logic        w_start, w_go, w_msg_ok, w_err_set;
  logic [31:0] w_rdata;

  // One access per two cycles: a new decode is blocked while ack is high.
  assign w_hit     = (bus.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_acc     = bus.wbs_stb_i & bus.wbs_cyc_i & active & w_hit & ~r_ack;
  assign w_wr      = w_acc & bus.wbs_we_i & (bus.wbs_sel_i == 4'hF);
  assign w_wr_ctrl = w_wr & (bus.wbs_adr_i[7:0] == 8'h00);
  assign w_wr_stat = w_wr & (bus.wbs_adr_i[7:0] == 8'h04);
  assign w_wr_msg  = w_wr & (bus.wbs_adr_i[7:0] == 8'h08);

  assign w_idle    = (r_state == S_IDLE);
  assign w_busy    = ~w_idle;
  assign w_full    = (r_count == 5'd16);
  assign w_start   = w_wr_ctrl & bus.wbs_dat_i[0];
  assign w_go      = w_start & w_idle & w_full;
  assign w_msg_ok  = w_wr_msg & w_idle & ~w_full;
  assign w_err_set = (w_wr_msg & ~w_msg_ok) | (w_start & w_idle & ~w_full);

  always_comb begin
    w_rdata = 32'h0;
    case (bus.wbs_adr_i[7:0])
      8'h00:   w_rdata = {29'h0, r_irq_en, r_init_en, 1'b0};
      8'h04:   w_rdata = {23'h0, r_count, 1'b0, r_err, r_done, w_busy};
      8'h10:   w_rdata = bus.core_digest[159:128];
      8'h14:   w_rdata = bus.core_digest[127:96];
      8'h18:   w_rdata = bus.core_digest[95:64];
      8'h1C:   w_rdata = bus.core_digest[63:32];
      8'h20:   w_rdata = bus.core_digest[31:0];
      default: w_rdata = 32'h0;
    endcase
  end

  // Buffer contents are don't-care after reset, so no reset branch here.
  always_ff @(posedge wb_clk_i) begin
    if (w_msg_ok) r_buf[r_count[3:0]] <= bus.wbs_dat_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state     <= S_IDLE;
      r_count     <= 5'd0;
      r_rd        <= 4'd0;
      r_ack       <= 1'b0;
      r_dat       <= 32'h0;
      r_valid     <= 1'b0;
      r_wdata     <= 32'h0;
      r_core_init <= 1'b0;
      r_init_en   <= 1'b0;
      r_irq_en    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc && !bus.wbs_we_i) ? w_rdata : 32'h0;

      if (w_wr_ctrl) begin
        r_init_en <= bus.wbs_dat_i[1];
        r_irq_en  <= bus.wbs_dat_i[2];
      end

      // Hardware set takes priority over a coinciding firmware W1C.
      if (w_err_set)                              r_err <= 1'b1;
      else if (w_wr_stat && bus.wbs_dat_i[2])     r_err <= 1'b0;

      if (r_state == S_DONE)                      r_done <= 1'b1;
      else if (w_go || (w_wr_stat && bus.wbs_dat_i[1])) r_done <= 1'b0;

      if (w_msg_ok) r_count <= r_count + 5'd1;

      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_state     <= S_FEED;
            r_rd        <= 4'd0;
            r_valid     <= 1'b1;
            r_wdata     <= r_buf[0];
            r_core_init <= bus.wbs_dat_i[1];
          end
        end
        S_FEED: begin
          if (bus.core_w_ready) begin
            r_core_init <= 1'b0;
            if (r_rd == 4'd15) begin
              r_state <= S_WAIT;
              r_valid <= 1'b0;
              r_wdata <= 32'h0;
              r_count <= 5'd0;
            end else begin
              r_rd    <= r_rd + 4'd1;
              r_wdata <= r_buf[r_rd + 4'd1];
            end
          end
        end
        S_WAIT: begin
          if (bus.core_done) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.wbs_ack_o    = r_ack;
  assign bus.wbs_dat_o    = r_dat;
  assign bus.core_w_valid = r_valid;
  assign bus.core_w_data  = r_wdata;
  assign bus.core_init    = r_core_init;
  assign irq              = active & r_done & r_irq_en;
endmodule

// File: tb/tb_sha1_block_sequencer.sv
// Randomized bench for sha1_block_sequencer: a queue-based register/flag model
// predicts STATUS, beat order, core_init, irq timing and digest reads.
module tb_sha1_block_sequencer;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic wb_clk_i  = 1'b0;
  logic wb_rst_ni = 1'b0;
  logic active    = 1'b1;
  logic irq;

  sha1_block_sequencer_if bus();

  sha1_block_sequencer #(.BASE_ADDR(BASE)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .active    (active),
    .irq       (irq),
    .bus       (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  int unsigned q[$];
  int unsigned blk[$];
  int unsigned beat_q[$];
  bit          init_q[$];
  int          n_vcyc = 0;
  logic [31:0] last_data = 32'h0;
  bit          last_stall = 1'b0;
  int          rdy_mode = 0;
  bit          m_err, m_done, m_init, m_irqen, m_busy;
  logic [159:0] digest;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge wb_clk_i) begin
    #1;
    case (rdy_mode)
      0:       bus.core_w_ready = 1'b1;
      1:       bus.core_w_ready = ~bus.core_w_ready;
      default: bus.core_w_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Stream monitor: beats, stall stability, valid-cycle count.
  always @(negedge wb_clk_i) begin
    if (wb_rst_ni) begin
      if (last_stall) begin
        chk("stall_vld", 32'(bus.core_w_valid), 32'd1);
        chk("stall_data", bus.core_w_data, last_data);
      end
      if (bus.core_w_valid) n_vcyc++;
      if (bus.core_w_valid && bus.core_w_ready) begin
        beat_q.push_back(bus.core_w_data);
        init_q.push_back(bus.core_init);
      end
      last_stall = bus.core_w_valid && !bus.core_w_ready;
      last_data  = bus.core_w_data;
    end else begin
      last_stall = 1'b0;
    end
  end

  task automatic wb_go(input bit we, input logic [7:0] off, input logic [31:0] d,
                       input logic [3:0] sel, input int budget,
                       output logic [31:0] rd, output bit ok);
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = BASE | {24'h0, off}; bus.wbs_dat_i = d; bus.wbs_sel_i = sel;
    ok = 1'b0; rd = 32'h0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge wb_clk_i); #1;
      if (bus.wbs_ack_o) begin ok = 1'b1; rd = bus.wbs_dat_o; end
    end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic wb_wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] rd; bit ok;
    @(negedge wb_clk_i);
    wb_go(1'b1, off, d, sel, 10, rd, ok);
    chk("wr_ack", 32'(ok), 32'd1);
  endtask

  task automatic wb_rd(input logic [7:0] off, output logic [31:0] d);
    bit ok;
    @(negedge wb_clk_i);
    wb_go(1'b0, off, 32'h0, 4'hF, 10, d, ok);
    chk("rd_ack", 32'(ok), 32'd1);
  endtask

  function automatic logic [31:0] exp_status();
    return {23'h0, 5'(q.size()), 1'b0, m_err, m_done, m_busy};
  endfunction

  task automatic chk_status(input string tag);
    logic [31:0] r;
    wb_rd(8'h04, r);
    chk(tag, r, exp_status());
  endtask

  task automatic msg_push(input logic [31:0] d);
    wb_wr(8'h08, d, 4'hF);
    if (!m_busy && q.size() < 16) q.push_back(d);
    else m_err = 1'b1;
  endtask

  task automatic stat_w1c(input logic [2:0] v);
    wb_wr(8'h04, {29'h0, v}, 4'hF);
    if (v[1]) m_done = 1'b0;
    if (v[2]) m_err  = 1'b0;
  endtask

  // CTRL write; a successful START is checked to present word 0 in the ack cycle.
  task automatic ctrl_wr(input logic [2:0] v);
    bit go;
    go = v[0] && !m_busy && q.size() == 16;
    if (go) begin beat_q.delete(); init_q.delete(); n_vcyc = 0; end
    wb_wr(8'h00, {29'h0, v}, 4'hF);
    m_init = v[1]; m_irqen = v[2];
    if (v[0] && !m_busy) begin
      if (go) begin m_busy = 1'b1; m_done = 1'b0; blk = q; end
      else m_err = 1'b1;
    end
    if (go) begin
      chk("start_vld", 32'(bus.core_w_valid), 32'd1);
      chk("start_data", bus.core_w_data, blk[0]);
      chk("start_init", 32'(bus.core_init), 32'(m_init));
    end
  endtask

  task automatic feed_check(input int mode);
    int t = 0;
    while (beat_q.size() < 16 && t < 300) begin @(negedge wb_clk_i); t++; end
    chk("beats", 32'(beat_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < beat_q.size(); i++) begin
      chk("beat_data", beat_q[i], blk[i]);
      chk("beat_init", 32'(init_q[i]), (i == 0) ? 32'(m_init) : 32'd0);
    end
    @(posedge wb_clk_i); #1;
    chk("feed_end_vld", 32'(bus.core_w_valid), 32'd0);
    if (mode == 0)      chk("feed_cyc", 32'(n_vcyc), 32'd16);
    else if (mode == 1) chk("feed_cyc_tog", 32'(n_vcyc == 31 || n_vcyc == 32), 32'd1);
    else                chk("feed_cyc_rnd", 32'(n_vcyc >= 16), 32'd1);
    q.delete();
  endtask

  task automatic finish_block(input int gap);
    repeat (gap) @(posedge wb_clk_i);
    digest = {$urandom, $urandom, $urandom, $urandom, $urandom};
    bus.core_digest = digest;
    @(posedge wb_clk_i); #1; bus.core_done = 1'b1;
    @(posedge wb_clk_i); #1; bus.core_done = 1'b0;
    chk("irq_n1", 32'(irq), 32'd0);
    @(posedge wb_clk_i); #1;
    m_done = 1'b1; m_busy = 1'b0;
    chk("irq_n2", 32'(irq), 32'(m_irqen & active));
  endtask

  task automatic chk_digest(input int i);
    logic [31:0] r;
    wb_rd(8'(8'h10 + 4 * i), r);
    chk("digest", r, digest[159 - 32 * i -: 32]);
  endtask

  task automatic fill_rand();
    while (q.size() < 16) msg_push($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time budget exhausted");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [2:0]  v;
    bit          ok;
    int          k;
    bus.wbs_stb_i = 0; bus.wbs_cyc_i = 0; bus.wbs_we_i = 0; bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = 0; bus.wbs_dat_i = 0; bus.core_done = 0; bus.core_digest = '0;
    {m_err, m_done, m_init, m_irqen, m_busy} = '0;
    digest = '0;

    // Reset state
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
    chk("rst_dat", bus.wbs_dat_o, 32'h0);
    chk("rst_vld", 32'(bus.core_w_valid), 32'd0);
    chk("rst_wdata", bus.core_w_data, 32'h0);
    chk("rst_init", 32'(bus.core_init), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(negedge wb_clk_i) wb_rst_ni = 1'b1;
    chk_status("rst_status");

    // Known block with INIT, ready held high, done 80 cycles later
    rdy_mode = 0;
    msg_push(32'h6162_6380);
    for (int i = 1; i < 15; i++) msg_push(32'h0);
    msg_push(32'h0000_0018);
    chk_status("full_status");
    ctrl_wr(3'b011);
    feed_check(0);
    chk_status("wait_status");
    finish_block(80);
    chk_status("done_status");
    for (int i = 0; i < 5; i++) chk_digest(i);

    // START with 5 words: error, no stream
    for (int i = 0; i < 5; i++) msg_push($urandom);
    n_vcyc = 0;
    ctrl_wr(3'b001);
    repeat (5) @(posedge wb_clk_i);
    chk("short_no_vld", 32'(n_vcyc), 32'd0);
    chk_status("short_err");
    stat_w1c(3'b100);
    chk_status("err_w1c");
    wb_wr(8'h08, 32'hdead_beef, 4'h3);
    chk_status("sel_ignored");
    wb_rd(8'h0C, r); chk("hole_rd", r, 32'h0);
    wb_rd(8'h08, r); chk("msg_rd", r, 32'h0);
    wb_rd(8'h00, r); chk("ctrl_rd", r, {29'h0, m_irqen, m_init, 1'b0});
    @(posedge wb_clk_i); #1; bus.core_done = 1'b1;
    @(posedge wb_clk_i); #1; bus.core_done = 1'b0;
    chk_status("idle_done_ignored");

    // Toggling ready, IRQ_EN, MSG while busy sets ERR
    rdy_mode = 1;
    fill_rand();
    ctrl_wr(3'b101);
    msg_push(32'h1234_5678);
    feed_check(1);
    finish_block(5);
    chk_status("tog_done_err");
    stat_w1c(3'b010);
    chk("irq_clr", 32'(irq), 32'd0);
    stat_w1c(3'b100);
    chk_status("tog_cleared");

    // W1C DONE decoded in the same cycle the done state sets it
    rdy_mode = 0;
    fill_rand();
    ctrl_wr(3'b101);
    feed_check(0);
    @(posedge wb_clk_i); #1; bus.core_done = 1'b1;
    @(posedge wb_clk_i); #1; bus.core_done = 1'b0;
    wb_go(1'b1, 8'h04, 32'h2, 4'hF, 10, r, ok);
    chk("w1c_race_ack", 32'(ok), 32'd1);
    m_done = 1'b1; m_busy = 1'b0;
    chk_status("w1c_race_done");
    chk("w1c_race_irq", 32'(irq), 32'd1);

    // Reset after 7 beats
    fill_rand();
    ctrl_wr(3'b011);
    k = 0;
    while (beat_q.size() < 7 && k < 100) begin @(negedge wb_clk_i); k++; end
    chk("pre_rst_beats", 32'(beat_q.size()), 32'd7);
    @(posedge wb_clk_i); #1;
    wb_rst_ni = 1'b0;
    #1;
    chk("mrst_vld", 32'(bus.core_w_valid), 32'd0);
    chk("mrst_wdata", bus.core_w_data, 32'h0);
    chk("mrst_init", 32'(bus.core_init), 32'd0);
    chk("mrst_ack", 32'(bus.wbs_ack_o), 32'd0);
    chk("mrst_irq", 32'(irq), 32'd0);
    q.delete();
    {m_err, m_done, m_init, m_irqen, m_busy} = '0;
    @(negedge wb_clk_i) wb_rst_ni = 1'b1;
    chk_status("post_rst_status");
    wb_rd(8'h00, r); chk("post_rst_ctrl", r, 32'h0);
    fill_rand();
    msg_push(32'h0bad_0bad);
    chk_status("overflow_err");

    // active low: no ack, irq masked
    ctrl_wr(3'b101);
    feed_check(0);
    finish_block(3);
    @(negedge wb_clk_i) active = 1'b0;
    #1 chk("inactive_irq", 32'(irq), 32'd0);
    wb_go(1'b0, 8'h04, 32'h0, 4'hF, 20, r, ok);
    chk("inactive_noack", 32'(ok), 32'd0);
    @(negedge wb_clk_i) active = 1'b1;
    #1 chk("active_irq", 32'(irq), 32'd1);
    chk_status("active_status");
    stat_w1c(3'b110);

    // Randomized blocks
    for (int it = 0; it < 6; it++) begin
      rdy_mode = int'($urandom_range(0, 2));
      k = int'($urandom_range(0, 15));
      for (int j = 0; j < k; j++) msg_push($urandom);
      v = 3'($urandom_range(0, 7));
      ctrl_wr({v[2:1], 1'b1});
      chk_status("rnd_partial");
      fill_rand();
      if ($urandom_range(0, 1) == 1) msg_push($urandom);
      v = 3'($urandom_range(0, 7));
      ctrl_wr({v[2:1], 1'b1});
      feed_check(rdy_mode);
      chk_status("rnd_wait");
      finish_block(int'($urandom_range(0, 20)));
      chk_status("rnd_done");
      chk_digest(int'($urandom_range(0, 4)));
      stat_w1c(3'($urandom_range(0, 3)) << 1);
      chk_status("rnd_w1c");
    end

    repeat (4) @(posedge wb_clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
